// File: rtl/bp_me_pkg.sv
// bp_me_pkg: message types, geometry and size helpers for the
// I/O CCE to MMIO register bus adapter.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg = 2'd0
  } bp_params_e;

  typedef struct packed {
    int paddr_width;
    int cce_block_width;
    int lce_id_width;
    int lce_assoc;
  } bp_proc_param_s;

  localparam int bp_paddr_width_gp = 40;
  localparam int bp_cce_block_width_gp = 512;
  localparam int bp_lce_id_width_gp = 4;
  localparam int bp_lce_assoc_gp = 8;

  localparam bp_proc_param_s bp_inv_cfg_p = '{
    paddr_width: bp_paddr_width_gp,
    cce_block_width: bp_cce_block_width_gp,
    lce_id_width: bp_lce_id_width_gp,
    lce_assoc: bp_lce_assoc_gp
  };

  function automatic bp_proc_param_s bp_cfg(bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_inv_cfg: p = bp_inv_cfg_p;
      default: p = bp_inv_cfg_p;
    endcase
    return p;
  endfunction

  typedef enum logic [3:0] {
    e_cce_mem_rd = 4'd0,
    e_cce_mem_wr = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1 = 3'd0,
    e_mem_msg_size_2 = 3'd1,
    e_mem_msg_size_4 = 3'd2,
    e_mem_msg_size_8 = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [bp_lce_id_width_gp-1:0] lce_id;
    logic [$clog2(bp_lce_assoc_gp)-1:0] way_id;
    logic uncached;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e msg_type;
    logic [bp_paddr_width_gp-1:0] addr;
    bp_mem_msg_size_e size;
    bp_cce_mem_payload_s payload;
  } bp_cce_mem_hdr_s;

  typedef struct packed {
    bp_cce_mem_hdr_s header;
    logic [bp_cce_block_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    e_io_idle = 2'd0,
    e_io_req = 2'd1,
    e_io_wait = 2'd2,
    e_io_resp = 2'd3
  } bp_io_state_e;

  localparam logic [63:0] bp_io_mmio_err_data_gp = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [6:0] bp_io_size_to_bytes(logic [2:0] size);
    return 7'd1 << size;
  endfunction

  // Only 1/2/4/8-byte accesses naturally aligned within the 64-bit word
  function automatic logic bp_io_size_legal(logic [2:0] size,
                                            logic [2:0] addr_lsbs);
    logic [6:0] n;
    n = bp_io_size_to_bytes(size);
    return (size <= 3'd3) && ((addr_lsbs & 3'(n - 7'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/bp_io_mmio_lane_align.sv
// bp_io_mmio_lane_align: byte-lane mask, write replication and
// read-data alignment for one 64-bit MMIO word.
module bp_io_mmio_lane_align
  import bp_me_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  addr_lsbs,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  mask,
  output logic [63:0] wdata_rep,
  output logic [63:0] rdata_align
);

  logic [6:0]  n;
  logic [7:0]  lanes;
  logic [63:0] byte_mask;

  always_comb begin
    n = bp_io_size_to_bytes(size);
    lanes = 8'((9'd1 << n[3:0]) - 9'd1);
    mask = lanes << addr_lsbs;
    for (int i = 0; i < 8; i++) begin
      byte_mask[i*8 +: 8] = {8{lanes[i]}};
    end
    rdata_align = (rdata >> {addr_lsbs, 3'b000}) & byte_mask;
    wdata_rep = wdata;
    unique case (1'b1)
      (n == 7'd1): wdata_rep = {8{wdata[7:0]}};
      (n == 7'd2): wdata_rep = {4{wdata[15:0]}};
      (n == 7'd4): wdata_rep = {2{wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/bp_io_mmio_adapter.sv
// bp_io_mmio_adapter: bridges uncached I/O CCE commands onto a
// single-outstanding 64-bit MMIO bus with an ack timeout.
module bp_io_mmio_adapter
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int timeout_cycles_p = 1024,
  parameter int mmio_data_width_p = 64,
  localparam bp_proc_param_s cfg_lp = bp_cfg(bp_params_p),
  localparam int paddr_width_p = cfg_lp.paddr_width,
  localparam int cce_block_width_p = cfg_lp.cce_block_width
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,
  output logic                            mmio_v_o,
  output logic                            mmio_w_o,
  output logic [paddr_width_p-1:0]        mmio_addr_o,
  output logic [mmio_data_width_p-1:0]    mmio_data_o,
  output logic [mmio_data_width_p/8-1:0]  mmio_mask_o,
  input  logic                            mmio_ready_i,
  input  logic                            mmio_v_i,
  input  logic [mmio_data_width_p-1:0]    mmio_data_i,
  output logic                            timeout_o
);

  localparam int cnt_width_lp = $clog2(timeout_cycles_p);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp =
    cnt_width_lp'(timeout_cycles_p - 1);

  bp_io_state_e state_r, state_n;
  bp_cce_mem_hdr_s hdr_r;
  logic [63:0] wdata_r, rdata_r;
  logic [cnt_width_lp-1:0] cnt_r;

  bp_cce_mem_msg_s cmd, resp;
  logic accept, legal, is_wr, ack, expire;
  logic [7:0] lane_mask;
  logic [63:0] wdata_rep, rdata_align;
  logic unused_cmd_data;

  assign cmd = bp_cce_mem_msg_s'(io_cmd_i);
  assign unused_cmd_data = ^cmd.data[cce_block_width_p-1:64];
  assign accept = io_cmd_v_i & io_cmd_ready_o;
  assign legal = bp_io_size_legal(cmd.header.size, cmd.header.addr[2:0]);
  assign is_wr = (hdr_r.msg_type == e_cce_mem_uc_wr);
  assign ack = (state_r == e_io_wait) & mmio_v_i;
  // A real ack in the final cycle beats the timeout
  assign expire = (state_r == e_io_wait) & ~mmio_v_i & (cnt_r == cnt_max_lp);

  bp_io_mmio_lane_align align (
    .size        (hdr_r.size),
    .addr_lsbs   (hdr_r.addr[2:0]),
    .wdata       (wdata_r),
    .rdata       (mmio_data_i),
    .mask        (lane_mask),
    .wdata_rep   (wdata_rep),
    .rdata_align (rdata_align)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_io_idle;
    else state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_io_idle: if (accept) state_n = legal ? e_io_req : e_io_resp;
      e_io_req: if (mmio_ready_i) state_n = e_io_wait;
      e_io_wait: if (ack | expire) state_n = e_io_resp;
      e_io_resp: if (io_resp_yumi_i) state_n = e_io_idle;
      default: state_n = e_io_idle;
    endcase
  end

  // Read data preloads to the error pattern; a real ack overwrites it
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hdr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      cnt_r <= '0;
    end else begin
      if (accept) begin
        hdr_r <= cmd.header;
        wdata_r <= cmd.data[63:0];
        rdata_r <= bp_io_mmio_err_data_gp;
      end
      if (state_r == e_io_req) cnt_r <= '0;
      else if (state_r == e_io_wait) cnt_r <= cnt_r + cnt_width_lp'(1);
      if (ack & ~is_wr) rdata_r <= rdata_align;
    end
  end

  always_comb begin
    io_cmd_ready_o = 1'b0;
    io_resp_v_o = 1'b0;
    resp = '0;
    mmio_v_o = 1'b0;
    mmio_w_o = 1'b0;
    mmio_addr_o = '0;
    mmio_data_o = '0;
    mmio_mask_o = '0;
    timeout_o = 1'b0;
    unique case (state_r)
      e_io_idle: io_cmd_ready_o = ~reset_i;
      e_io_req: begin
        mmio_v_o = 1'b1;
        mmio_w_o = is_wr;
        mmio_addr_o = hdr_r.addr;
        mmio_data_o = wdata_rep;
        mmio_mask_o = lane_mask;
      end
      e_io_wait: timeout_o = expire;
      e_io_resp: begin
        io_resp_v_o = 1'b1;
        resp.header = hdr_r;
        resp.data = is_wr ? '0
                  : {{(cce_block_width_p-64){1'b0}}, rdata_r};
      end
      default: ;
    endcase
  end

  assign io_resp_o = resp;

endmodule

// File: tb/tb_bp_io_mmio_adapter.sv
// tb_bp_io_mmio_adapter: directed checks of the I/O MMIO adapter
// built with a 16-cycle ack timeout.
module tb_bp_io_mmio_adapter;
  import bp_me_pkg::*;

  localparam int to_lp = 16;
  localparam int msg_w_lp = $bits(bp_cce_mem_msg_s);
  localparam int hi_w_lp = bp_cce_block_width_gp - 64;

  logic clk = 1'b0;
  logic reset_i;
  logic [msg_w_lp-1:0] io_cmd_i, io_resp_o;
  logic io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
  logic mmio_v_o, mmio_w_o, mmio_ready_i, mmio_v_i, timeout_o;
  logic [bp_paddr_width_gp-1:0] mmio_addr_o;
  logic [63:0] mmio_data_o, mmio_data_i;
  logic [7:0] mmio_mask_o;

  int errors = 0;
  int checks = 0;
  bp_cce_mem_msg_s c;

  always #5 clk = ~clk;

  bp_io_mmio_adapter #(
    .timeout_cycles_p(to_lp)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .io_cmd_i       (io_cmd_i),
    .io_cmd_v_i     (io_cmd_v_i),
    .io_cmd_ready_o (io_cmd_ready_o),
    .io_resp_o      (io_resp_o),
    .io_resp_v_o    (io_resp_v_o),
    .io_resp_yumi_i (io_resp_yumi_i),
    .mmio_v_o       (mmio_v_o),
    .mmio_w_o       (mmio_w_o),
    .mmio_addr_o    (mmio_addr_o),
    .mmio_data_o    (mmio_data_o),
    .mmio_mask_o    (mmio_mask_o),
    .mmio_ready_i   (mmio_ready_i),
    .mmio_v_i       (mmio_v_i),
    .mmio_data_i    (mmio_data_i),
    .timeout_o      (timeout_o)
  );

  function automatic bp_cce_mem_msg_s mk(bp_cce_mem_cmd_type_e t,
                                         logic [39:0] a,
                                         bp_mem_msg_size_e s,
                                         logic [3:0] lce,
                                         logic [63:0] d);
    bp_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type = t;
    m.header.addr = a;
    m.header.size = s;
    m.header.payload.lce_id = lce;
    m.header.payload.way_id = 3'd5;
    m.header.payload.uncached = 1'b1;
    m.data = {{hi_w_lp{1'b1}}, d};
    return m;
  endfunction

  function automatic bp_cce_mem_msg_s rsp(bp_cce_mem_msg_s cm,
                                          logic [63:0] d);
    bp_cce_mem_msg_s m;
    m = '0;
    m.header = cm.header;
    m.data[63:0] = d;
    return m;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input bp_cce_mem_msg_s exp);
    checks++;
    assert (io_resp_o === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, io_resp_o, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    io_cmd_i = '0;
    io_cmd_v_i = 1'b0;
    io_resp_yumi_i = 1'b0;
    mmio_ready_i = 1'b0;
    mmio_v_i = 1'b0;
    mmio_data_i = '0;

    // reset
    nxt(); settle();
    chk("rst_ready", 64'(io_cmd_ready_o), 64'(0));
    chk("rst_mmio_v", 64'(mmio_v_o), 64'(0));
    chk("rst_resp_v", 64'(io_resp_v_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    nxt(); reset_i = 1'b0; settle();
    chk("post_rst_ready", 64'(io_cmd_ready_o), 64'(1));

    // 4-byte write, ack in second wait cycle
    c = mk(e_cce_mem_uc_wr, 40'h00_0010_0004, e_mem_msg_size_4, 4'd3,
           64'h0000_0000_DEAD_BEEF);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    nxt(); io_cmd_v_i = 1'b0; mmio_ready_i = 1'b1; settle();
    chk("wr_v", 64'(mmio_v_o), 64'(1));
    chk("wr_w", 64'(mmio_w_o), 64'(1));
    chk("wr_addr", 64'(mmio_addr_o), 64'h0010_0004);
    chk("wr_mask", 64'(mmio_mask_o), 64'hF0);
    chk("wr_data", mmio_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("wr_busy", 64'(io_cmd_ready_o), 64'(0));
    nxt(); mmio_ready_i = 1'b0; settle();
    chk("wr_wait_v", 64'(mmio_v_o), 64'(0));
    nxt(); mmio_v_i = 1'b1; mmio_data_i = 64'h5555_AAAA_5555_AAAA; settle();
    nxt(); mmio_v_i = 1'b0; settle();
    chk("wr_resp_v", 64'(io_resp_v_o), 64'(1));
    chk_resp("wr_resp", rsp(c, 64'h0));
    io_resp_yumi_i = 1'b1;
    nxt(); io_resp_yumi_i = 1'b0; settle();
    chk("wr_done_v", 64'(io_resp_v_o), 64'(0));
    chk("wr_done_ready", 64'(io_cmd_ready_o), 64'(1));

    // 1-byte read, minimum latency
    c = mk(e_cce_mem_uc_rd, 40'h00_0010_0003, e_mem_msg_size_1, 4'd7,
           64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    nxt(); io_cmd_v_i = 1'b0; mmio_ready_i = 1'b1; settle();
    chk("rd_v_c1", 64'(mmio_v_o), 64'(1));
    chk("rd_w", 64'(mmio_w_o), 64'(0));
    chk("rd_mask", 64'(mmio_mask_o), 64'h08);
    nxt(); mmio_ready_i = 1'b0; mmio_v_i = 1'b1;
    mmio_data_i = 64'h0011_2233_4455_6677; settle();
    chk("rd_resp_v_c2", 64'(io_resp_v_o), 64'(0));
    nxt(); mmio_v_i = 1'b0; mmio_data_i = '0; settle();
    chk("rd_resp_v_c3", 64'(io_resp_v_o), 64'(1));
    chk_resp("rd_resp", rsp(c, 64'h44));
    io_resp_yumi_i = 1'b1;
    nxt(); io_resp_yumi_i = 1'b0; settle();

    // 2-byte read with no ack: timeout
    c = mk(e_cce_mem_uc_rd, 40'h00_0010_0002, e_mem_msg_size_2, 4'd9,
           64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    nxt(); io_cmd_v_i = 1'b0; mmio_ready_i = 1'b1; settle();
    chk("to_req_v", 64'(mmio_v_o), 64'(1));
    for (int k = 1; k <= to_lp; k++) begin
      nxt(); mmio_ready_i = 1'b0; settle();
      chk($sformatf("to_pulse_%0d", k), 64'(timeout_o), 64'(k == to_lp));
    end
    nxt(); settle();
    chk("to_resp_v", 64'(io_resp_v_o), 64'(1));
    chk("to_pulse_end", 64'(timeout_o), 64'(0));
    chk_resp("to_resp", rsp(c, 64'hFFFF_FFFF_FFFF_FFFF));
    nxt(); settle();
    nxt(); mmio_v_i = 1'b1; mmio_data_i = 64'h0123_4567_89AB_CDEF; settle();
    chk("to_late_pulse", 64'(timeout_o), 64'(0));
    nxt(); mmio_v_i = 1'b0; settle();
    chk_resp("to_resp_hold", rsp(c, 64'hFFFF_FFFF_FFFF_FFFF));
    io_resp_yumi_i = 1'b1;
    nxt(); io_resp_yumi_i = 1'b0; settle();
    chk("to_done_ready", 64'(io_cmd_ready_o), 64'(1));

    // misaligned 8-byte read: no bus transaction
    c = mk(e_cce_mem_uc_rd, 40'h00_0010_0004, e_mem_msg_size_8, 4'd4,
           64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1; settle();
    chk("mis_c0_mmio_v", 64'(mmio_v_o), 64'(0));
    nxt(); io_cmd_v_i = 1'b0; settle();
    chk("mis_mmio_v", 64'(mmio_v_o), 64'(0));
    chk("mis_resp_v", 64'(io_resp_v_o), 64'(1));
    chk("mis_timeout", 64'(timeout_o), 64'(0));
    chk_resp("mis_resp", rsp(c, 64'hFFFF_FFFF_FFFF_FFFF));
    io_resp_yumi_i = 1'b1;
    nxt(); io_resp_yumi_i = 1'b0; settle();
    chk("mis_idle_mmio_v", 64'(mmio_v_o), 64'(0));

    // back-pressure on both bus and response
    c = mk(e_cce_mem_uc_wr, 40'h00_0010_0006, e_mem_msg_size_2, 4'd2,
           64'h0000_1234_ABCD_5678);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    nxt(); io_cmd_v_i = 1'b0;
    io_cmd_i = mk(e_cce_mem_uc_rd, 40'hFF_FFFF_FFF8, e_mem_msg_size_8,
                  4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
    settle();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) mmio_ready_i = 1'b1;
      settle();
      chk($sformatf("bp_v_%0d", k), 64'(mmio_v_o), 64'(1));
      chk($sformatf("bp_addr_%0d", k), 64'(mmio_addr_o), 64'h0010_0006);
      chk($sformatf("bp_mask_%0d", k), 64'(mmio_mask_o), 64'hC0);
      chk($sformatf("bp_data_%0d", k), mmio_data_o, 64'h5678_5678_5678_5678);
      chk($sformatf("bp_busy_%0d", k), 64'(io_cmd_ready_o), 64'(0));
      nxt();
    end
    mmio_ready_i = 1'b0; mmio_v_i = 1'b1; settle();
    nxt(); mmio_v_i = 1'b0; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_resp_v_%0d", k), 64'(io_resp_v_o), 64'(1));
      chk_resp($sformatf("bp_resp_%0d", k), rsp(c, 64'h0));
      chk($sformatf("bp_rbusy_%0d", k), 64'(io_cmd_ready_o), 64'(0));
      nxt(); settle();
    end
    c = mk(e_cce_mem_uc_rd, 40'h00_0010_0008, e_mem_msg_size_4, 4'd1,
           64'h0);
    io_resp_yumi_i = 1'b1; io_cmd_i = c; io_cmd_v_i = 1'b1; settle();
    chk("bp_yumi_ready", 64'(io_cmd_ready_o), 64'(0));
    nxt(); io_resp_yumi_i = 1'b0; settle();
    chk("bp_after_ready", 64'(io_cmd_ready_o), 64'(1));
    chk("bp_after_mmio_v", 64'(mmio_v_o), 64'(0));

    // reset pulse while waiting for an ack
    nxt(); io_cmd_v_i = 1'b0; mmio_ready_i = 1'b1; settle();
    chk("rw_req_v", 64'(mmio_v_o), 64'(1));
    nxt(); mmio_ready_i = 1'b0; reset_i = 1'b1; settle();
    chk("rw_rst_ready", 64'(io_cmd_ready_o), 64'(0));
    nxt(); reset_i = 1'b0; settle();
    chk("rw_ready", 64'(io_cmd_ready_o), 64'(1));
    chk("rw_mmio_v", 64'(mmio_v_o), 64'(0));
    chk("rw_resp_v", 64'(io_resp_v_o), 64'(0));
    chk("rw_timeout", 64'(timeout_o), 64'(0));
    chk("rw_mask", 64'(mmio_mask_o), 64'h0);
    chk_resp("rw_resp", bp_cce_mem_msg_s'('0));
    mmio_v_i = 1'b1; mmio_data_i = 64'hFFFF_0000_FFFF_0000;
    nxt(); mmio_v_i = 1'b0; settle();
    chk("rw_late_resp_v", 64'(io_resp_v_o), 64'(0));
    chk("rw_late_ready", 64'(io_cmd_ready_o), 64'(1));

    c = mk(e_cce_mem_uc_rd, 40'h00_0010_000C, e_mem_msg_size_4, 4'd6,
           64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    nxt(); io_cmd_v_i = 1'b0; mmio_ready_i = 1'b1; settle();
    chk("nc_mask", 64'(mmio_mask_o), 64'hF0);
    chk("nc_addr", 64'(mmio_addr_o), 64'h0010_000C);
    nxt(); mmio_ready_i = 1'b0; mmio_v_i = 1'b1;
    mmio_data_i = 64'hCAFE_F00D_0BAD_BEEF; settle();
    nxt(); mmio_v_i = 1'b0; settle();
    chk("nc_resp_v", 64'(io_resp_v_o), 64'(1));
    chk_resp("nc_resp", rsp(c, 64'h0000_0000_CAFE_F00D));
    io_resp_yumi_i = 1'b1;
    nxt(); io_resp_yumi_i = 1'b0; settle();
    chk("nc_done_v", 64'(io_resp_v_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
